fp_add_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_align_shift.sv | 30 +++
 rtl/fp_add_seq.sv | 184 ++++++++++++++++++
 tb/tb_fp_add_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Purpose: shared types and constants for the sequential single-precision adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam int          MANT_W  = 23;
  localparam int          GRS_W   = 3;
  // hidden bit + fraction + guard/round/sticky
  localparam int          WORK_W  = 1 + MANT_W + GRS_W;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp_fields;

endpackage

// File: rtl/fp_align_shift.sv
// Purpose: right shifter for the smaller operand's working mantissa; every bit
//          shifted past the LSB is ORed into the sticky (LSB) position.
// Latency: combinational. Backpressure: none.
// Ports: i_mant (27b in), i_dist (8b shift distance), o_mant (27b out with sticky).
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [WORK_W-1:0] i_mant,
  input  logic [7:0]        i_dist,
  output logic [WORK_W-1:0] o_mant
);

  logic [WORK_W-1:0] w_shifted;
  logic [WORK_W-1:0] w_lost_mask;
  logic              w_lost;

  assign w_shifted   = i_mant >> i_dist;
  // mask of the low bits that fall off the end for distances below the width
  assign w_lost_mask = ~({WORK_W{1'b1}} << i_dist);
  assign w_lost      = |(i_mant & w_lost_mask);

  always_comb begin
    if (i_dist >= 8'(WORK_W)) begin
      o_mant = {{(WORK_W-1){1'b0}}, |i_mant};
    end else begin
      o_mant = {w_shifted[WORK_W-1:1], w_shifted[0] | w_lost};
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Purpose: multi-cycle IEEE-754 single adder (RNE, subnormals flushed to zero).
// Latency: done 2 edges after start for specials, 5+n for arithmetic (n = norm cycles).
// Backpressure: start is only taken in IDLE; start while busy is dropped, no queue.
// Ports: clk/rst (async high), start/a/b request, result/done/ovf reply, busy status.
module fp_add_seq
  import fp_pkg::*;
#(
  parameter bit SUB = 1'b0
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf
);

  state_t             r_state, w_next;
  fp_fields           r_a, r_b;
  logic [WORK_W-1:0]  r_ma, r_mb;
  logic [WORK_W:0]    r_sum;
  logic signed [9:0]  r_exp;
  logic               r_sign, r_sub, r_zero;
  logic [31:0]        r_res_nxt, r_result;
  logic               r_ovf_nxt, r_ovf, r_fin, r_done;

  // ---------------- UNPACK: special operand classification ----------------
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        w_special;
  logic [31:0] w_spec_res;

  assign w_a_nan  = (r_a.exp == EXP_MAX) && (r_a.mant != '0);
  assign w_b_nan  = (r_b.exp == EXP_MAX) && (r_b.mant != '0);
  assign w_a_inf  = (r_a.exp == EXP_MAX) && (r_a.mant == '0);
  assign w_b_inf  = (r_b.exp == EXP_MAX) && (r_b.mant == '0);
  assign w_a_zero = (r_a.exp == 8'd0);
  assign w_b_zero = (r_b.exp == 8'd0);

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan)                          w_spec_res = QNAN;
    else if (w_a_inf && w_b_inf && (r_a.sign != r_b.sign)) w_spec_res = QNAN;
    else if (w_a_inf)                                w_spec_res = r_a;
    else if (w_b_inf)                                w_spec_res = r_b;
    else if (w_a_zero && w_b_zero)                   w_spec_res = {r_a.sign & r_b.sign, 31'd0};
    else if (w_a_zero)                               w_spec_res = r_b;
    else if (w_b_zero)                               w_spec_res = r_a;
    else                                             w_special  = 1'b0;
  end

  // ---------------- ALIGN: order by magnitude, shift the smaller ----------------
  logic              w_swap;
  fp_fields          w_big, w_sml;
  logic [7:0]        w_dist;
  logic [WORK_W-1:0] w_mbig, w_msml_in, w_msml;

  assign w_swap    = {r_b.exp, r_b.mant} > {r_a.exp, r_a.mant};
  assign w_big     = w_swap ? r_b : r_a;
  assign w_sml     = w_swap ? r_a : r_b;
  assign w_dist    = w_big.exp - w_sml.exp;
  assign w_mbig    = {1'b1, w_big.mant, {GRS_W{1'b0}}};
  assign w_msml_in = {1'b1, w_sml.mant, {GRS_W{1'b0}}};

  fp_align_shift u_align (
    .i_mant (w_msml_in),
    .i_dist (w_dist),
    .o_mant (w_msml)
  );

  // ---------------- ROUND: nearest-even on G and (R|S) ----------------
  logic [WORK_W-1:0] w_m;
  logic              w_up, w_rovf;
  logic [24:0]       w_rm;
  logic signed [9:0] w_rexp;
  logic [22:0]       w_frac;
  logic [31:0]       w_round_res;

  assign w_m    = r_sum[WORK_W-1:0];
  assign w_up   = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
  assign w_rm   = {1'b0, w_m[26:3]} + {24'd0, w_up};
  // a carry out of the mantissa leaves 1.000..., so the fraction is all zero
  assign w_rexp = r_exp + $signed({9'd0, w_rm[24]});
  assign w_frac = w_rm[24] ? w_rm[23:1] : w_rm[22:0];
  assign w_rovf = !r_zero && (w_rexp >= 10'sd255);

  always_comb begin
    if (r_zero)      w_round_res = {r_sign, 31'd0};
    else if (w_rovf) w_round_res = {r_sign, EXP_MAX, 23'd0};
    else             w_round_res = {r_sign, w_rexp[7:0], w_frac};
  end

  // ---------------- FSM ----------------
  logic w_norm_end;
  assign w_norm_end = (r_sum == '0) || r_sum[27] || r_sum[26] || (r_exp <= 10'sd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK;
      S_UNPACK: w_next = w_special ? S_IDLE : S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   if (w_norm_end) w_next = S_ROUND;
      S_ROUND:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- datapath and output register ----------------
  // r_fin marks the cycle a result is ready; the output register publishes it
  // on the following edge together with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_ma <= '0; r_mb <= '0; r_sum <= '0; r_exp <= '0;
      r_sign <= 1'b0; r_sub <= 1'b0; r_zero <= 1'b0;
      r_res_nxt <= '0; r_ovf_nxt <= 1'b0; r_fin <= 1'b0;
      r_result <= '0; r_ovf <= 1'b0; r_done <= 1'b0;
    end else begin
      r_fin  <= 1'b0;
      r_done <= r_fin;
      if (r_fin) begin
        r_result <= r_res_nxt;
        r_ovf    <= r_ovf_nxt;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_a    <= fp_fields'(a);
          r_b    <= fp_fields'({b[31] ^ SUB, b[30:0]});
          r_zero <= 1'b0;
        end
        S_UNPACK: if (w_special) begin
          r_res_nxt <= w_spec_res;
          r_ovf_nxt <= 1'b0;
          r_fin     <= 1'b1;
        end
        S_ALIGN: begin
          r_ma   <= w_mbig;
          r_mb   <= w_msml;
          r_exp  <= $signed({2'b00, w_big.exp});
          r_sign <= w_big.sign;
          r_sub  <= w_big.sign ^ w_sml.sign;
        end
        S_ADD: r_sum <= r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
        S_NORM: begin
          if (r_sum == '0) begin
            r_zero <= 1'b1;
            r_sign <= 1'b0;
          end else if (r_sum[27]) begin
            r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 10'sd1;
          end else if (!r_sum[26]) begin
            if (r_exp <= 10'sd1) r_zero <= 1'b1;
            else begin
              r_sum <= {r_sum[26:0], 1'b0};
              r_exp <= r_exp - 10'sd1;
            end
          end
        end
        S_ROUND: begin
          r_res_nxt <= w_round_res;
          r_ovf_nxt <= w_rovf;
          r_fin     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign ovf    = r_ovf;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_add_seq.sv
// Purpose: directed self-checking bench for fp_add_seq (a+b configuration).
// Latency: counts edges from the start-accepting edge (edge 0) to done.
// Backpressure: checks that start while busy is dropped and start with done is taken.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        done, busy, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_seq #(.SUB(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE; returns result/ovf and the edge count at done
  // (-1 if done never arrived within the budget).
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] res, output logic o, output int lat);
    start = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; res = 'x; o = 1'bx;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = e; res = result; o = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want %h", result, 32'h0); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_one_plus_one();
    int lat;
    logic busy_ok;
    busy_ok = 1'b1;
    lat = -1;
    start = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (e <= 4 && busy !== 1'b1) busy_ok = 1'b0;
      if (e >= 5 && busy !== 1'b0) busy_ok = 1'b0;
      if (done) begin lat = e; break; end
    end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL add11_latency got %0d want 6", lat); end
    n_tests++; if (result !== 32'h40000000) begin n_fail++; $display("FAIL add11_result got %h want 40000000", result); end
    n_tests++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL add11_busy_window got %b want 1", busy_ok); end
    // done must be a single-cycle pulse
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL add11_done_pulse got %b want 0", done); end
  endtask

  task automatic test_cancel_norm();
    logic [31:0] r; logic o; int lat;
    do_op(32'h3FC00000, 32'hBF800000, r, o, lat);
    n_tests++; if (r !== 32'h3F000000) begin n_fail++; $display("FAIL sub_norm_result got %h want 3F000000", r); end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL sub_norm_latency got %0d want 7", lat); end
  endtask

  task automatic test_rounding();
    logic [31:0] r; logic o; int lat;
    do_op(32'h3F800000, 32'h33800000, r, o, lat);
    n_tests++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL round_tie_even got %h want 3F800000", r); end
    do_op(32'h3F800000, 32'h33C00000, r, o, lat);
    n_tests++; if (r !== 32'h3F800001) begin n_fail++; $display("FAIL round_up got %h want 3F800001", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL round_up_latency got %0d want 6", lat); end
  endtask

  task automatic test_specials();
    logic [31:0] r; logic o; int lat;
    logic [31:0] va [6] = '{32'h7F800000, 32'h7FC00001, 32'h00000000, 32'h7F800000, 32'h80000000, 32'hC0400000};
    logic [31:0] vb [6] = '{32'hFF800000, 32'h3F800000, 32'h40A00000, 32'h3F800000, 32'h80000000, 32'h00000000};
    logic [31:0] vr [6] = '{32'h7FC00000, 32'h7FC00000, 32'h40A00000, 32'h7F800000, 32'h80000000, 32'hC0400000};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], r, o, lat);
      n_tests++; if (r !== vr[i]) begin n_fail++; $display("FAIL special%0d_result got %h want %h", i, r, vr[i]); end
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL special%0d_latency got %0d want 2", i, lat); end
    end
    // exact cancellation runs the arithmetic path and yields +0
    do_op(32'h3F800000, 32'hBF800000, r, o, lat);
    n_tests++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL cancel_zero_result got %h want 00000000", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL cancel_zero_latency got %0d want 6", lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic o; int lat;
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, r, o, lat);
    n_tests++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_result got %h want 7F800000", r); end
    n_tests++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    start = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    @(posedge clk); #1;          // edge 0 -> UNPACK
    start = 1'b0;
    @(posedge clk); #1;          // ALIGN
    @(posedge clk); #1;          // ADD
    rst = 1'b1;
    #2;
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", result); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got %b want 0", seen); end
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    lat = -1; extra = 0;
    start = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    @(posedge clk); #1;
    a = 32'h40000000; b = 32'h40000000;   // held high while busy; must be dropped
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (e == 3) start = 1'b0;
      if (done) begin lat = e; break; end
    end
    n_tests++; if (result !== 32'h40000000) begin n_fail++; $display("FAIL busy_ignore_result got %h want 40000000", result); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 6", lat); end
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL busy_ignore_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic o; int lat;
    do_op(32'h3F800000, 32'h3F800000, r, o, lat);
    n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL b2b_first got %h want 40000000", r); end
    // issued in the done cycle of the first operation
    do_op(32'h40000000, 32'h3F800000, r, o, lat);
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL b2b_second got %h want 40400000", r); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL b2b_latency got %0d want 6", lat); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", o); end
  endtask

  initial begin
    test_reset();
    test_one_plus_one();
    test_cancel_norm();
    test_rounding();
    test_specials();
    test_overflow();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
